// File: rtl/dec_pkg.sv
// Shared types and helpers for the one-hot strobe decoder: FSM state encoding,
// binary-to-one-hot conversion and timer width sizing.
package dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int MAX_IN_W  = 8;
  localparam int MAX_OUT_W = 1 << MAX_IN_W;

  // Callers truncate the result to their own output width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] code);
    logic [MAX_OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  function automatic int cnt_w(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dec_timer.sv
// Loadable down-counter with a zero flag; times both the HOLD and GAP phases.
module dec_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dec_onehot_strobe.sv
// Binary code in (valid/ready), timed one-hot strobe out: HOLD cycles driven, GAP cycles idle.
// Optional even-parity check on the code is enabled by defining DEC_PARITY_CHK_EN.
module dec_onehot_strobe
  import dec_pkg::*;
#(
  parameter int IN_W = 3,
  parameter int HOLD = 4,
  parameter int GAP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_code,
`ifdef DEC_PARITY_CHK_EN
  input  logic                 in_par,
`endif
  output logic [(1<<IN_W)-1:0] out,
  output logic                 out_active,
  output logic                 done,
  output logic                 err
);

  localparam int OUT_W   = 1 << IN_W;
  localparam int CW      = cnt_w(HOLD, GAP);
  localparam int HOLD_LD = (HOLD > 0) ? HOLD - 1 : 0;
  localparam int GAP_LD  = (GAP > 0) ? GAP - 1 : 0;

  if (HOLD < 1) begin : g_hold_chk
    $error("dec_onehot_strobe: HOLD must be >= 1");
  end
  if (IN_W < 1 || IN_W > MAX_IN_W) begin : g_inw_chk
    $error("dec_onehot_strobe: IN_W out of range");
  end

  state_t           state, state_nxt;
  logic             xfer, par_ok;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CW-1:0]    tmr_val;
  logic [OUT_W-1:0] out_nxt;
  logic             done_nxt;

  assign xfer = in_valid && in_ready;

`ifdef DEC_PARITY_CHK_EN
  assign par_ok = ~^{in_par, in_code};
`else
  assign par_ok = 1'b1;
`endif

  dec_timer #(
    .CNT_W (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer && par_ok) begin
          state_nxt = ST_DRIVE;
          tmr_load  = 1'b1;
          tmr_val   = CW'(HOLD_LD);
        end
      end
      ST_DRIVE: begin
        if (tmr_zero) begin
          if (GAP > 0) begin
            state_nxt = ST_GAP;
            tmr_load  = 1'b1;
            tmr_val   = CW'(GAP_LD);
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_nxt = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // out_nxt is only ever zero or a single decoded bit, so out stays one-hot across transitions.
  always_comb begin
    in_ready   = (state == ST_IDLE);
    out_active = (state == ST_DRIVE);
    out_nxt    = '0;
    done_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer && par_ok) begin
          out_nxt = OUT_W'(onehot(MAX_IN_W'(in_code)));
        end
      end
      ST_DRIVE: begin
        if (!tmr_zero) begin
          out_nxt = out;
        end else if (GAP == 0) begin
          done_nxt = 1'b1;
        end
      end
      ST_GAP: begin
        done_nxt = tmr_zero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      done <= 1'b0;
    end else begin
      out  <= out_nxt;
      done <= done_nxt;
    end
  end

`ifdef DEC_PARITY_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= xfer && !par_ok;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dec_onehot_strobe.sv
// Directed bench for dec_onehot_strobe (HOLD=4/GAP=2 and a GAP=0 instance).
// Parity cases are compiled in when DEC_PARITY_CHK_EN is defined.
module tb_dec_onehot_strobe;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready;
  logic [2:0] in_code;
  logic [7:0] out;
  logic       out_active, done, err;

  logic       in_valid2, in_ready2;
  logic [2:0] in_code2;
  logic [7:0] out2;
  logic       out_active2, done2, err2;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DEC_PARITY_CHK_EN
  logic in_par, in_par2, par_bad;
  assign in_par  = (^in_code) ^ par_bad;
  assign in_par2 = ^in_code2;
`endif

  dec_onehot_strobe #(.IN_W(3), .HOLD(4), .GAP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
`ifdef DEC_PARITY_CHK_EN
    .in_par     (in_par),
`endif
    .out        (out),
    .out_active (out_active),
    .done       (done),
    .err        (err)
  );

  dec_onehot_strobe #(.IN_W(3), .HOLD(4), .GAP(0)) dut_g0 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .in_code    (in_code2),
`ifdef DEC_PARITY_CHK_EN
    .in_par     (in_par2),
`endif
    .out        (out2),
    .out_active (out_active2),
    .done       (done2),
    .err        (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       vld;
    logic [2:0] code;
    logic [7:0] exp_out;
    logic       exp_rdy;
    logic       exp_done;
    logic       exp_act;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_o;

    // Code 5 full sequence, then a code-2 strobe with ignored codes offered mid-DRIVE and mid-GAP.
    tbl[0]  = '{1'b1, 3'd5, 8'h20, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 3'd5, 8'h20, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 3'd5, 8'h20, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 3'd5, 8'h20, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'd5, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 3'd2, 8'h04, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 3'd7, 8'h04, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 3'd1, 8'h04, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 3'd1, 8'h04, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 3'd6, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 3'd6, 8'h00, 1'b1, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    in_valid2 = 1'b0;
    in_code2  = '0;
`ifdef DEC_PARITY_CHK_EN
    par_bad   = 1'b0;
`endif

    // Reset and idle
    step();
    step();
    chk("rst_out", out, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_out", out, 8'h00);
      chk("idle_ready", in_ready, 1'b1);
      chk("idle_done", done, 1'b0);
      chk("idle_act", out_active, 1'b0);
      chk("idle_err", err, 1'b0);
    end

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      in_valid = tbl[i].vld;
      in_code  = tbl[i].code;
      step();
      chk($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].exp_done);
      chk($sformatf("tbl%0d_act", i), out_active, tbl[i].exp_act);
    end
    in_valid = 1'b0;

    // Back-to-back sweep with in_valid held: transfers every 7 cycles
    in_valid = 1'b1;
    in_code  = 3'd0;
    for (int c = 0; c < 8; c++) begin
      step();
      exp_o = 8'h01 << c;
      chk($sformatf("sweep%0d_out", c), out, exp_o);
      chk($sformatf("sweep%0d_act", c), out_active, 1'b1);
      in_code = 3'(c + 1);
      if (c == 7) in_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        step();
        chk($sformatf("sweep%0d_k%0d_out", c, k), out, (k <= 3) ? exp_o : 8'h00);
        chk("sweep_onehot", ($countones(out) <= 1), 1'b1);
        chk($sformatf("sweep%0d_k%0d_ready", c, k), in_ready, (k == 6));
        chk($sformatf("sweep%0d_k%0d_done", c, k), done, (k == 6));
      end
    end

    // Async reset in the second DRIVE cycle
    in_valid = 1'b1;
    in_code  = 3'd4;
    step();
    in_valid = 1'b0;
    step();
    chk("prerst_out", out, 8'h10);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out", out, 8'h00);
    chk("async_rst_act", out_active, 1'b0);
    step();
    chk("rst_hold_done", done, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", in_ready, 1'b1);
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_out", out, 8'h00);
    in_valid = 1'b1;
    in_code  = 3'd0;
    step();
    in_valid = 1'b0;
    chk("post_rst_code0", out, 8'h01);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("post_rst_k%0d_done", k), done, (k == 6));
    end

`ifdef DEC_PARITY_CHK_EN
    // Bad parity rejected, then good parity decoded
    par_bad  = 1'b1;
    in_code  = 3'd3;
    in_valid = 1'b1;
    step();
    chk("par_bad_err", err, 1'b1);
    chk("par_bad_out", out, 8'h00);
    chk("par_bad_ready", in_ready, 1'b1);
    chk("par_bad_act", out_active, 1'b0);
    in_valid = 1'b0;
    par_bad  = 1'b0;
    step();
    chk("par_bad_err_clr", err, 1'b0);
    chk("par_bad_done", done, 1'b0);
    chk("par_bad_out2", out, 8'h00);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("par_good_out", out, 8'h08);
    chk("par_good_err", err, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("par_good_k%0d_done", k), done, (k == 6));
    end
`endif

    // GAP=0 instance: done and ready right after HOLD, next transfer 5 cycles later
    chk("g0_idle_ready", in_ready2, 1'b1);
    in_valid2 = 1'b1;
    in_code2  = 3'd3;
    step();
    in_valid2 = 1'b0;
    chk("g0_out", out2, 8'h08);
    chk("g0_act", out_active2, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("g0_k%0d_out", k), out2, 8'h08);
      chk($sformatf("g0_k%0d_ready", k), in_ready2, 1'b0);
    end
    step();
    chk("g0_end_out", out2, 8'h00);
    chk("g0_end_ready", in_ready2, 1'b1);
    chk("g0_end_done", done2, 1'b1);
    chk("g0_err", err2, 1'b0);
    in_valid2 = 1'b1;
    in_code2  = 3'd6;
    step();
    in_valid2 = 1'b0;
    chk("g0_next_out", out2, 8'h40);
    chk("g0_next_done", done2, 1'b0);
    for (int k = 0; k < 5; k++) step();
    chk("g0_final_ready", in_ready2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
